// File: rtl/goomba_gravity_mover.sv
// Vertical motion for one goomba: rests on solid tiles, falls under integer gravity,
// snaps onto the first solid row it would cross, and retires once off-screen or removed.
module goomba_gravity_mover #(
    parameter int BLK             = 2,
    parameter int GND             = 3,
    parameter int CHARACTER_WIDTH = 42,
    parameter int SCREEN_WIDTH    = 640,
    parameter int SCREEN_HEIGHT   = 480,
    parameter int BLOCK_WIDTH     = 40,
    parameter int MAX_FALL_SPEED  = 4,
    parameter int GRAVITY_DIV     = 8
) (
    input  logic                   movement_clock,
    input  logic                   reset,
    input  logic [11:0][16:0][7:0] background,
    input  int                     goomba_x,
    input  int                     goomba_y_initial,
    output int                     goomba_y,
    output logic                   falling,
    output logic                   fell_out
);

    typedef enum logic [1:0] {INIT, GROUNDED, FALLING, GONE} state_t;

    state_t r_state, w_state_nxt;
    int     r_y, w_y_nxt;
    int     r_speed, w_speed_nxt;
    int     r_grav, w_grav_nxt;
    logic   r_falling, r_fell, w_fell_nxt;

    int     w_cl, w_cr, w_bot, w_rs, w_rp, w_fall_y;
    logic   w_supported, w_probe_solid, w_killed;

    function automatic int clamp_col(input int c);
        if (c < 0)  return 0;
        if (c > 16) return 16;
        return c;
    endfunction

    function automatic logic is_solid(input logic [7:0] code);
        return (code == 8'(BLK)) || (code == 8'(GND));
    endfunction

    // Rows outside the map (above or below) never block the goomba.
    function automatic logic row_solid(input logic [11:0][16:0][7:0] bg,
                                       input int r, input int cl, input int cr);
        logic [3:0] ri;
        logic [4:0] li, rj;
        if (r < 0 || r > 11) return 1'b0;
        ri = r[3:0];
        li = cl[4:0];
        rj = cr[4:0];
        return is_solid(bg[ri][li]) || is_solid(bg[ri][rj]);
    endfunction

    always_comb begin
        w_cl          = clamp_col(goomba_x / BLOCK_WIDTH);
        w_cr          = clamp_col((goomba_x + CHARACTER_WIDTH - 1) / BLOCK_WIDTH);
        w_bot         = r_y + CHARACTER_WIDTH;
        w_rs          = w_bot / BLOCK_WIDTH;
        w_rp          = (w_bot + r_speed - 1) / BLOCK_WIDTH;
        w_fall_y      = r_y + r_speed;
        w_supported   = ((w_bot % BLOCK_WIDTH) == 0) && row_solid(background, w_rs, w_cl, w_cr);
        w_probe_solid = row_solid(background, w_rp, w_cl, w_cr);
        w_killed      = goomba_x >= SCREEN_WIDTH;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_y_nxt     = r_y;
        w_speed_nxt = r_speed;
        w_grav_nxt  = r_grav;
        w_fell_nxt  = r_fell;
        case (r_state)
            INIT: begin
                if (w_supported) begin
                    w_state_nxt = GROUNDED;
                end else begin
                    w_state_nxt = FALLING;
                    w_speed_nxt = 1;
                    w_grav_nxt  = 0;
                end
            end
            GROUNDED: begin
                if (w_killed) begin
                    w_state_nxt = GONE;
                end else if (!w_supported) begin
                    w_state_nxt = FALLING;
                    w_speed_nxt = 1;
                    w_grav_nxt  = 0;
                end
            end
            FALLING: begin
                if (w_killed) begin
                    w_state_nxt = GONE;
                end else if (w_rp > w_rs && w_probe_solid) begin
                    // Snap to the top of the row the step would have entered.
                    w_state_nxt = GROUNDED;
                    w_y_nxt     = w_rp * BLOCK_WIDTH - CHARACTER_WIDTH;
                    w_speed_nxt = 0;
                end else begin
                    w_y_nxt = w_fall_y;
                    if (r_grav == GRAVITY_DIV - 1) begin
                        w_grav_nxt = 0;
                        if (r_speed < MAX_FALL_SPEED) w_speed_nxt = r_speed + 1;
                    end else begin
                        w_grav_nxt = r_grav + 1;
                    end
                    if (w_fall_y >= SCREEN_HEIGHT) begin
                        w_y_nxt     = SCREEN_HEIGHT;
                        w_fell_nxt  = 1'b1;
                        w_state_nxt = GONE;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge movement_clock) begin
        if (reset) begin
            r_state   <= INIT;
            r_y       <= goomba_y_initial;
            r_speed   <= 0;
            r_grav    <= 0;
            r_falling <= 1'b0;
            r_fell    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_y       <= w_y_nxt;
            r_speed   <= w_speed_nxt;
            r_grav    <= w_grav_nxt;
            r_falling <= (w_state_nxt == FALLING);
            r_fell    <= w_fell_nxt;
        end
    end

    assign goomba_y = r_y;
    assign falling  = r_falling;
    assign fell_out = r_fell;

endmodule

// File: tb/tb_goomba_gravity_mover.sv
// Directed bench for goomba_gravity_mover: a vector table of settle-and-check cases
// plus hand sequences for fall stepping, removal mid-fall and reset recovery.
module tb_goomba_gravity_mover;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic [11:0][16:0][7:0] bg;
    int                     gx, gy0;
    int                     gy;
    logic                   falling, fell_out;

    int checks = 0;
    int failures = 0;

    goomba_gravity_mover dut (
        .movement_clock   (clk),
        .reset            (reset),
        .background       (bg),
        .goomba_x         (gx),
        .goomba_y_initial (gy0),
        .goomba_y         (gy),
        .falling          (falling),
        .fell_out         (fell_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    bg_sel;
        int    x;
        int    yinit;
        int    ticks;
        int    exp_y;
        int    exp_fall;
        int    exp_fell;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // 0: row 11 solid ground; 1: gap at columns 2-3 of row 11; 2: ground plus brick at (8,3)
    task automatic set_bg(input int sel);
        bg = '0;
        for (int c = 0; c < 17; c++) bg[11][c] = 8'd3;
        if (sel == 1) begin
            bg[11][2] = 8'd0;
            bg[11][3] = 8'd0;
        end
        if (sel == 2) bg[8][3] = 8'd2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int prev, mono_ok;
        vecs[0]  = '{"ground_hold",   0,  100, 398,  20, 398, 0, 0};
        vecs[1]  = '{"fall_land",     0,  100, 100, 200, 398, 0, 0};
        vecs[2]  = '{"gap_fall_out",  1,   85, 398, 200, 480, 0, 1};
        vecs[3]  = '{"blk_land",      2,  120,   0, 200, 278, 0, 0};
        vecs[4]  = '{"init_to_fall",  0,  100, 100,   1, 100, 1, 0};
        vecs[5]  = '{"fall_8_ticks",  0,  100, 100,   9, 108, 1, 0};
        vecs[6]  = '{"left_edge",     0,    0, 398,   5, 398, 0, 0};
        vecs[7]  = '{"neg_x_clamp",   0, -100, 398,   5, 398, 0, 0};
        vecs[8]  = '{"right_clamp",   0,  639, 398,   5, 398, 0, 0};
        vecs[9]  = '{"x_at_width",    0,  640, 100,  10, 100, 0, 0};
        vecs[10] = '{"x_below_width", 0,  639, 100,   3, 102, 1, 0};
        vecs[11] = '{"blk_stand",     2,  120, 278,   5, 278, 0, 0};
        vecs[12] = '{"gap_half",      1,   60, 398,   5, 398, 0, 0};

        set_bg(0);
        gx = 100;
        gy0 = 398;
        tick();

        // Reset state
        do_reset();
        chk("reset_y", gy, 398);
        chk("reset_falling", int'(falling), 0);
        chk("reset_fell_out", int'(fell_out), 0);

        for (int i = 0; i < 13; i++) begin
            set_bg(vecs[i].bg_sel);
            gx  = vecs[i].x;
            gy0 = vecs[i].yinit;
            do_reset();
            prev = gy;
            mono_ok = 1;
            for (int t = 0; t < vecs[i].ticks; t++) begin
                tick();
                if (gy < prev) mono_ok = 0;
                prev = gy;
            end
            chk({vecs[i].name, "_y"}, gy, vecs[i].exp_y);
            chk({vecs[i].name, "_falling"}, int'(falling), vecs[i].exp_fall);
            chk({vecs[i].name, "_fell_out"}, int'(fell_out), vecs[i].exp_fell);
            chk({vecs[i].name, "_monotonic"}, mono_ok, 1);
        end

        // Fall stepping: +1 for 8 ticks, then +2 for 8 ticks
        set_bg(0);
        gx = 100;
        gy0 = 100;
        do_reset();
        tick();
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("step_y", gy, (k <= 8) ? 100 + k : 108 + 2 * (k - 8));
        end

        // Removal mid-fall freezes y without setting fell_out
        gx = 100;
        gy0 = 200;
        do_reset();
        tick();
        chk("kill_pre_falling", int'(falling), 1);
        gx = 1000;
        tick();
        chk("kill_y", gy, 200);
        chk("kill_falling", int'(falling), 0);
        chk("kill_fell_out", int'(fell_out), 0);
        gx = 100;
        for (int k = 0; k < 3; k++) tick();
        chk("kill_absorbing_y", gy, 200);
        chk("kill_absorbing_falling", int'(falling), 0);

        // Reset mid-fall at y=250 with speed 3
        gx = 100;
        gy0 = 205;
        do_reset();
        for (int k = 0; k < 24; k++) tick();
        chk("midfall_y", gy, 250);
        chk("midfall_falling", int'(falling), 1);
        gy0 = 50;
        reset = 1'b1;
        tick();
        chk("midfall_reset_y", gy, 50);
        chk("midfall_reset_falling", int'(falling), 0);
        reset = 1'b0;
        tick();
        tick();
        chk("midfall_speed_restart", gy, 51);

        // Reset out of GONE after falling off-screen
        set_bg(1);
        gx = 85;
        gy0 = 398;
        do_reset();
        for (int k = 0; k < 100; k++) tick();
        chk("gone_fell_out", int'(fell_out), 1);
        chk("gone_y", gy, 480);
        set_bg(0);
        reset = 1'b1;
        tick();
        chk("gone_reset_fell_out", int'(fell_out), 0);
        chk("gone_reset_y", gy, 398);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        chk("gone_regrounded_y", gy, 398);
        chk("gone_regrounded_falling", int'(falling), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/goomba_gravity_mover.md
GOOMBA_GRAVITY_MOVER -- requirements
Module: goomba_gravity_mover

Interface
REQ-001 Parameter BLK, default 2, background code for a solid brick block.
REQ-002 Parameter GND, default 3, background code for solid ground.
REQ-003 Parameter CHARACTER_WIDTH, default 42, goomba sprite edge length in pixels.
REQ-004 Parameter SCREEN_WIDTH, default 640, horizontal pixel extent.
REQ-005 Parameter SCREEN_HEIGHT, default 480, vertical pixel extent.
REQ-006 Parameter BLOCK_WIDTH, default 40, tile edge length in pixels.
REQ-007 Parameter MAX_FALL_SPEED, default 4, fall speed ceiling in pixels per tick.
REQ-008 Parameter GRAVITY_DIV, default 8, FALLING ticks per speed increment.
REQ-009 movement_clock  input  1  sole clock, one movement tick per rising edge.
REQ-010 reset  input  1  synchronous, active-high reset.
REQ-011 background  input  byte [11:0][16:0]  tile map, [row][column].
REQ-012 goomba_x  input  int  goomba left edge from the left-right mover.
REQ-013 goomba_y_initial  input  int  spawn top edge, loaded at reset.
REQ-014 goomba_y  output  int  goomba top edge, consumed by the left-right mover.
REQ-015 falling  output  1  high while in FALLING.
REQ-016 fell_out  output  1  sticky, high once the goomba has dropped below the screen.

Function
REQ-017 Footprint columns SHALL be cl = goomba_x/BLOCK_WIDTH and cr = (goomba_x+CHARACTER_WIDTH-1)/BLOCK_WIDTH, each clamped to 0..16.
REQ-018 Tile (r, c) SHALL be solid iff background[r][c] is BLK or GND; any r > 11 SHALL be non-solid.
REQ-019 Support row SHALL be rs = (goomba_y+CHARACTER_WIDTH)/BLOCK_WIDTH; supported means (rs,cl) or (rs,cr) is solid, and goomba_y+CHARACTER_WIDTH is an exact multiple of BLOCK_WIDTH.
REQ-020 The FSM SHALL have states INIT, GROUNDED, FALLING and GONE, with one transition per movement_clock edge.
REQ-021 INIT SHALL go to GROUNDED if supported, else to FALLING with speed 1.
REQ-022 GROUNDED SHALL hold goomba_y; if not supported it goes to FALLING with speed 1 and the gravity counter at 0.
REQ-023 FALLING probe: nb = goomba_y+CHARACTER_WIDTH+speed; probe row rp = (nb-1)/BLOCK_WIDTH.
REQ-024 If rp is deeper than the current support row and (rp,cl) or (rp,cr) is solid, the block SHALL land: goomba_y <= rp*BLOCK_WIDTH-CHARACTER_WIDTH, speed <= 0, state GROUNDED, same cycle.
REQ-025 Otherwise goomba_y SHALL increase by speed.
REQ-026 The gravity counter SHALL increment each FALLING tick; on reaching GRAVITY_DIV-1 it wraps to 0 and speed increments, saturating at MAX_FALL_SPEED.
REQ-027 If FALLING would produce goomba_y >= SCREEN_HEIGHT, goomba_y SHALL be set to SCREEN_HEIGHT, fell_out to 1, and the state to GONE.
REQ-028 From any non-INIT state, goomba_x >= SCREEN_WIDTH (goomba killed or removed) SHALL force GONE with goomba_y held and fell_out unchanged; this has priority over landing and falling.
REQ-029 GONE SHALL be absorbing until reset and SHALL hold all outputs.
REQ-030 goomba_y SHALL never decrease except on reset or on the landing snap of REQ-024.
REQ-031 falling SHALL be registered and asserted exactly on cycles whose state register is FALLING.

Reset
REQ-032 When reset is high at an edge: state <= INIT, goomba_y <= goomba_y_initial, speed <= 0, gravity counter <= 0, falling <= 0, fell_out <= 0; this SHALL apply from any state, including mid-fall and GONE.
REQ-033 There SHALL be no reset-free initial values; all outputs are defined one edge after reset is asserted.

Verification
REQ-034 Row 11 all GND, goomba_x=100, goomba_y_initial=398, reset pulse -> GROUNDED; goomba_y stays 398 and falling=0 for 20 ticks.
REQ-035 Row 11 GND, goomba_x=100, initial y=100 -> falling=1; y steps +1 for 8 ticks, then +2 per tick, ramping to +4; lands with goomba_y=398 exactly, no overshoot, falling=0.
REQ-036 Row 11 cols 2-3 SKY, elsewhere GND, goomba_x=85, initial y=398 -> FALLING the tick after INIT; goomba_y reaches 480, fell_out=1, values held.
REQ-037 Goomba mid-fall at y=200, goomba_x set to 1000 -> GONE next edge; goomba_y frozen at its current value, fell_out=0.
REQ-038 Reset asserted mid-fall (y=250, speed 3) -> next edge goomba_y=goomba_y_initial, falling=0, speed 0; GONE also exits on reset.
REQ-039 BLK tile at (8,3), goomba_x=120, initial y=0 -> lands at goomba_y=278, GROUNDED.
